braun_multiplier_pipe: RTL and testbench

- Parametrised, pipelined successor to the combinational Braun array multiplier.
- Computes the N x N product with an N-row Braun carry-save array. The rows are partitioned across STAGES register boundaries.
- Uses a valid/ready handshake on both sides, so it can sit between streaming datapath blocks with back-pressure.

---
 rtl/braun_multiplier_pipe_if.sv | 27 ++
 rtl/braun_multiplier_pipe.sv | 162 ++++++++++++++++
 tb/tb_braun_multiplier_pipe.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/braun_multiplier_pipe_if.sv
// Streaming handshake bundle for braun_multiplier_pipe: operand side (in_*, a, b)
// and product side (out_*, p). The tc port exists only when BRAUN_SIGNED_EN is defined.
interface braun_multiplier_pipe_if #(
  parameter int N = 8
);
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] p;

`ifdef BRAUN_SIGNED_EN
  logic           tc;

  modport master (output in_valid, a, b, tc, out_ready,
                  input  in_ready, out_valid, p);
  modport slave  (input  in_valid, a, b, tc, out_ready,
                  output in_ready, out_valid, p);
`else
  modport master (output in_valid, a, b, out_ready,
                  input  in_ready, out_valid, p);
  modport slave  (input  in_valid, a, b, out_ready,
                  output in_ready, out_valid, p);
`endif
endinterface

// File: rtl/braun_multiplier_pipe.sv
// Pipelined N x N Braun carry-save array multiplier with valid/ready on both sides.
// Define BRAUN_SIGNED_EN to add the tc input selecting the Baugh-Wooley signed array.
module braun_multiplier_pipe #(
  parameter int N      = 8,
  parameter int STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  braun_multiplier_pipe_if.slave bus
);

  logic           st_valid [STAGES];
  logic [2*N-1:0] st_sum   [STAGES];
  logic [2*N-1:0] st_carry [STAGES];
  logic [N-1:0]   st_a     [STAGES];
  logic [N-1:0]   st_b     [STAGES];

  logic           nx_valid [STAGES];
  logic [2*N-1:0] nx_sum   [STAGES];
  logic [2*N-1:0] nx_carry [STAGES];
  logic [N-1:0]   nx_a     [STAGES];
  logic [N-1:0]   nx_b     [STAGES];

`ifdef BRAUN_SIGNED_EN
  logic           st_tc    [STAGES];
  logic           nx_tc    [STAGES];

  // Baugh-Wooley correction: +1 at bit N and at bit 2N-1, seeded into the carry vector.
  localparam logic [2*N-1:0] BW_CORR = {1'b1, {(2*N-1){1'b0}}} |
                                       ({{(2*N-1){1'b0}}, 1'b1} << N);
`endif

  logic stall;

  // Partial-product row i shifted into place; in signed mode the MSB row/column
  // terms are complemented except the a[N-1]&b[N-1] corner.
  function automatic logic [2*N-1:0] pp_row(input logic [N-1:0] av, input logic bi,
                                            input logic tcv, input int i);
    logic [N-1:0]   row;
    logic [2*N-1:0] ext;
    for (int j = 0; j < N; j++) begin
      row[j] = av[j] & bi;
      if (tcv && ((j == N-1) != (i == N-1)))
        row[j] = ~row[j];
    end
    ext = {{N{1'b0}}, row};
    return ext << i;
  endfunction

  function automatic logic [4*N-1:0] reduce_rows(input logic [2*N-1:0] s_in,
                                                 input logic [2*N-1:0] c_in,
                                                 input logic [N-1:0]   av,
                                                 input logic [N-1:0]   bv,
                                                 input logic           tcv,
                                                 input int             k);
    logic [2*N-1:0] s;
    logic [2*N-1:0] c;
    logic [2*N-1:0] r;
    logic [2*N-1:0] ns;
    s = s_in;
    c = c_in;
    for (int i = 0; i < N; i++) begin
      if ((i * STAGES) / N == k) begin
        r  = pp_row(av, bv[i], tcv, i);
        ns = s ^ c ^ r;
        c  = ((s & c) | (s & r) | (c & r)) << 1;
        s  = ns;
      end
    end
    return {c, s};
  endfunction

  function automatic logic [2*N-1:0] ripple_add(input logic [2*N-1:0] x,
                                                input logic [2*N-1:0] y);
    logic [2*N-1:0] r;
    logic           cy;
    cy = 1'b0;
    for (int j = 0; j < 2*N; j++) begin
      r[j] = x[j] ^ y[j] ^ cy;
      cy   = (x[j] & y[j]) | (cy & (x[j] ^ y[j]));
    end
    return r;
  endfunction

  assign stall         = st_valid[STAGES-1] & ~bus.out_ready;
  assign bus.in_ready  = ~stall;
  assign bus.out_valid = st_valid[STAGES-1];
  assign bus.p         = st_sum[STAGES-1];

  // Each stage reduces its share of rows; the last stage resolves the carry-save pair.
  always_comb begin
    logic [2*N-1:0] s_in;
    logic [2*N-1:0] c_in;
    logic [4*N-1:0] red;
    logic           tc_in;
    for (int k = 0; k < STAGES; k++) begin
      if (k == 0) begin
        nx_valid[k] = bus.in_valid;
        nx_a[k]     = bus.a;
        nx_b[k]     = bus.b;
        s_in        = '0;
`ifdef BRAUN_SIGNED_EN
        tc_in       = bus.tc;
        c_in        = bus.tc ? BW_CORR : '0;
`else
        tc_in       = 1'b0;
        c_in        = '0;
`endif
      end else begin
        nx_valid[k] = st_valid[k-1];
        nx_a[k]     = st_a[k-1];
        nx_b[k]     = st_b[k-1];
        s_in        = st_sum[k-1];
        c_in        = st_carry[k-1];
`ifdef BRAUN_SIGNED_EN
        tc_in       = st_tc[k-1];
`else
        tc_in       = 1'b0;
`endif
      end
`ifdef BRAUN_SIGNED_EN
      nx_tc[k] = tc_in;
`endif
      red = reduce_rows(s_in, c_in, nx_a[k], nx_b[k], tc_in, k);
      if (k == STAGES-1) begin
        nx_sum[k]   = ripple_add(red[2*N-1:0], red[4*N-1:2*N]);
        nx_carry[k] = '0;
      end else begin
        nx_sum[k]   = red[2*N-1:0];
        nx_carry[k] = red[4*N-1:2*N];
      end
    end
  end

  // A stall freezes the whole pipe, so the output register doubles as the hold buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        st_valid[k] <= 1'b0;
        st_sum[k]   <= '0;
        st_carry[k] <= '0;
        st_a[k]     <= '0;
        st_b[k]     <= '0;
`ifdef BRAUN_SIGNED_EN
        st_tc[k]    <= 1'b0;
`endif
      end
    end else if (!stall) begin
      for (int k = 0; k < STAGES; k++) begin
        st_valid[k] <= nx_valid[k];
        st_sum[k]   <= nx_sum[k];
        st_carry[k] <= nx_carry[k];
        st_a[k]     <= nx_a[k];
        st_b[k]     <= nx_b[k];
`ifdef BRAUN_SIGNED_EN
        st_tc[k]    <= nx_tc[k];
`endif
      end
    end
  end

endmodule

// File: tb/tb_braun_multiplier_pipe.sv
// Self-checking bench for braun_multiplier_pipe (N=8, STAGES=3) with a product scoreboard;
// signed-mode steps are included when BRAUN_SIGNED_EN is defined.
module tb_braun_multiplier_pipe;
  localparam int N      = 8;
  localparam int STAGES = 3;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   cyc;
  bit   ov_hist [0:4095];
  logic [2*N-1:0] exp_q [$];
  bit             prev_stall;
  logic [2*N-1:0] prev_p;

  braun_multiplier_pipe_if #(.N(N)) bif ();

  braun_multiplier_pipe #(.N(N), .STAGES(STAGES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  function automatic logic [2*N-1:0] model(input logic [N-1:0] av, input logic [N-1:0] bv,
                                           input logic tv);
    logic [2*N-1:0] xa;
    logic [2*N-1:0] xb;
    xa = tv ? {{N{av[N-1]}}, av} : {{N{1'b0}}, av};
    xb = tv ? {{N{bv[N-1]}}, bv} : {{N{1'b0}}, bv};
    return xa * xb;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare on output handshakes, record on input handshakes.
  always @(negedge clk) begin
    logic tcv;
    if (cyc < 4096) ov_hist[cyc] = bif.out_valid;
    if (rst) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checkOutput("stall_valid_stable", 64'(bif.out_valid), 64'd1);
        checkOutput("stall_p_stable", 64'(bif.p), 64'(prev_p));
      end
      if (bif.out_valid && bif.out_ready) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          failures++;
          $error("[TB] FAIL unexpected_output observed=%0h expected=none", bif.p);
        end
        if (exp_q.size() != 0) checkOutput("product", 64'(bif.p), 64'(exp_q.pop_front()));
      end
`ifdef BRAUN_SIGNED_EN
      tcv = bif.tc;
`else
      tcv = 1'b0;
`endif
      if (bif.in_valid && bif.in_ready) exp_q.push_back(model(bif.a, bif.b, tcv));
      prev_stall = bif.out_valid && !bif.out_ready;
      prev_p     = bif.p;
    end
  end

  // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
  task automatic applyStimulus(input logic [N-1:0] av, input logic [N-1:0] bv,
                               input logic tv, output int acc_cyc);
    bit done;
    done    = 1'b0;
    acc_cyc = -1;
    bif.in_valid = 1'b1;
    bif.a        = av;
    bif.b        = bv;
`ifdef BRAUN_SIGNED_EN
    bif.tc       = tv;
`endif
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (bif.in_ready) begin
        done    = 1'b1;
        acc_cyc = cyc;
      end
    end
    checks++;
    assert (done) else begin
      failures++;
      $error("[TB] FAIL accept_timeout observed=not_accepted expected=accepted a=%0h b=%0h tc=%0b", av, bv, tv);
    end
    @(posedge clk); #1;
    bif.in_valid = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 300 && (exp_q.size() != 0 || bif.out_valid); i++) @(negedge clk);
    checkOutput("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int  c0, c1, c2;
    bit  hold;
    bit  seen;
    checks   = 0;
    failures = 0;
    cyc      = 0;
    clk      = 1'b0;
    rst      = 1'b1;
    bif.in_valid  = 1'b0;
    bif.a         = '0;
    bif.b         = '0;
    bif.out_ready = 1'b1;
`ifdef BRAUN_SIGNED_EN
    bif.tc        = 1'b0;
`endif

    #2;
    checkOutput("reset_out_valid", 64'(bif.out_valid), 64'd0);
    checkOutput("reset_p", 64'(bif.p), 64'd0);
    checkOutput("reset_in_ready", 64'(bif.in_ready), 64'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("in_ready_after_release", 64'(bif.in_ready), 64'd1);

    $display("[TB] streaming three products back to back");
    applyStimulus(8'd255, 8'd255, 1'b0, c0);
    applyStimulus(8'd0,   8'd17,  1'b0, c1);
    applyStimulus(8'd12,  8'd10,  1'b0, c2);
    idleCycles(STAGES + 2);
    checkOutput("back_to_back_accept", 64'(c2 - c0), 64'd2);
    checkOutput("latency_not_early", 64'(ov_hist[c0+STAGES-1]), 64'd0);
    for (int j = 0; j < 3; j++)
      checkOutput("stream_out_valid", 64'(ov_hist[c0+STAGES+j]), 64'd1);
    checkOutput("stream_ends", 64'(ov_hist[c0+STAGES+3]), 64'd0);

    $display("[TB] back-pressure on the output");
    bif.out_ready = 1'b0;
    applyStimulus(8'd255, 8'd255, 1'b0, c0);
    applyStimulus(8'd1,   8'd2,   1'b0, c1);
    applyStimulus(8'd3,   8'd4,   1'b0, c2);
    seen = 1'b0;
    for (int i = 0; i < 32 && !seen; i++) begin
      @(negedge clk);
      seen = bif.out_valid;
    end
    checkOutput("bp_out_valid_arrives", 64'(seen), 64'd1);
    bif.in_valid = 1'b1;
    bif.a        = 8'd9;
    bif.b        = 8'd9;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      checkOutput("bp_p_held", 64'(bif.p), 64'd65025);
      checkOutput("bp_in_ready_low", 64'(bif.in_ready), 64'd0);
    end
    @(posedge clk); #1;
    bif.out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_held_input_taken", 64'(bif.in_ready), 64'd1);
    @(posedge clk); #1;
    bif.in_valid = 1'b0;
    waitDrain();

    $display("[TB] reset in the middle of operation");
    applyStimulus(8'd1, 8'd1, 1'b0, c0);
    applyStimulus(8'd2, 8'd2, 1'b0, c1);
    applyStimulus(8'd3, 8'd3, 1'b0, c2);
    rst = 1'b1;
    #1;
    checkOutput("midrst_out_valid", 64'(bif.out_valid), 64'd0);
    checkOutput("midrst_p", 64'(bif.p), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("midrst_in_ready", 64'(bif.in_ready), 64'd1);
    applyStimulus(8'd7, 8'd9, 1'b0, c0);
    idleCycles(STAGES + 2);
    for (int j = 0; j < STAGES; j++)
      checkOutput("midrst_no_stale", 64'(ov_hist[c0+j]), 64'd0);
    checkOutput("midrst_latency", 64'(ov_hist[c0+STAGES]), 64'd1);
    checkOutput("midrst_single", 64'(ov_hist[c0+STAGES+1]), 64'd0);

    $display("[TB] alternating bubbles");
    applyStimulus(8'hFF, 8'h02, 1'b0, c0);
    idleCycles(1);
    for (int j = 0; j < 3; j++) begin
      applyStimulus(8'hFF, 8'h02, 1'b0, c1);
      idleCycles(1);
    end
    idleCycles(STAGES + 2);
    for (int j = 0; j < 8; j++)
      checkOutput("bubble_pattern", 64'(ov_hist[c0+STAGES+j]), 64'((j % 2) == 0));

`ifdef BRAUN_SIGNED_EN
    $display("[TB] signed mode");
    applyStimulus(8'hFD, 8'h05, 1'b1, c0);
    applyStimulus(8'hFD, 8'h05, 1'b0, c1);
    applyStimulus(8'h80, 8'h80, 1'b1, c2);
    applyStimulus(8'h7F, 8'h80, 1'b1, c2);
    applyStimulus(8'hFF, 8'hFF, 1'b1, c2);
    waitDrain();
`endif

    $display("[TB] random traffic with random back-pressure");
    hold = 1'b0;
    for (int i = 0; i < 120; i++) begin
      if (!hold) begin
        bif.in_valid = ($urandom_range(0, 1) == 1);
        bif.a        = N'($urandom);
        bif.b        = N'($urandom);
`ifdef BRAUN_SIGNED_EN
        bif.tc       = ($urandom_range(0, 1) == 1);
`endif
      end
      bif.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      hold = bif.in_valid && !bif.in_ready;
      @(posedge clk); #1;
    end
    bif.in_valid  = 1'b0;
    bif.out_ready = 1'b1;
    waitDrain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
